// File: rtl/register_file_multiport.sv
`default_nettype none
// ============================================================================
// Module   : register_file_multiport
// Purpose  : General-purpose register file with three read ports (A, B, C),
//            two write ports (WB write-back, WB2 base-register update),
//            same-cycle write-to-read bypass and a post-reset initialisation
//            sequencer that writes one register per cycle. Read addresses at
//            or above NUM_REGS return the PC input (R15 alias).
// Ports    : clk, reset                    - clock, sync active-high reset
//            i_SRC_1/2/3                   - read addresses, ports A/B/C
//            i_Destination_Write_Back(_2)  - write addresses, WB / WB2
//            i_Write_Back_Data(_2)         - write data, WB / WB2
//            i_Sig_Write_Back_Enable(_2)   - write enables, WB / WB2
//            i_PC_Value                    - value for addresses >= NUM_REGS
//            o_A, o_B, o_C                 - read data, ports A/B/C
//            o_Ready                       - initialisation complete
// Revision : 1.0 - initial release
// ============================================================================
module register_file_multiport #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_REGS        = 15,
  parameter int INIT_MODE       = 1,
  parameter int REGISTERED_READ = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_SRC_1,
  input  logic [ADDR_WIDTH-1:0] i_SRC_2,
  input  logic [ADDR_WIDTH-1:0] i_SRC_3,
  input  logic [ADDR_WIDTH-1:0] i_Destination_Write_Back,
  input  logic [DATA_WIDTH-1:0] i_Write_Back_Data,
  input  logic                  i_Sig_Write_Back_Enable,
  input  logic [ADDR_WIDTH-1:0] i_Destination_Write_Back_2,
  input  logic [DATA_WIDTH-1:0] i_Write_Back_Data_2,
  input  logic                  i_Sig_Write_Back_Enable_2,
  input  logic [DATA_WIDTH-1:0] i_PC_Value,
  output logic [DATA_WIDTH-1:0] o_A,
  output logic [DATA_WIDTH-1:0] o_B,
  output logic [DATA_WIDTH-1:0] o_C,
  output logic                  o_Ready
);

  localparam logic [ADDR_WIDTH-1:0] c_num_regs = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] c_last_reg = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_next;

  logic [DATA_WIDTH-1:0] r_regs [0:NUM_REGS-1];

  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_init_val;
  logic                  w_wr1_en;
  logic                  w_wr2_en;

  logic [2:0][ADDR_WIDTH-1:0] w_src;
  logic [2:0][DATA_WIDTH-1:0] w_rd;

  // --------------------------------------------------------------------------
  // Initialisation sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_next = r_cnt + 1'b1;
        // The edge that writes the last register also completes init.
        if (r_cnt == c_last_reg) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        w_state_next = ST_READY;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  assign w_ready    = (r_state == ST_READY);
  assign o_Ready    = w_ready;
  assign w_init_val = (INIT_MODE != 0) ? DATA_WIDTH'(r_cnt) : '0;

  // Writes to PC-alias addresses have no storage and are dropped.
  assign w_wr1_en = w_ready && i_Sig_Write_Back_Enable &&
                    (i_Destination_Write_Back < c_num_regs);
  assign w_wr2_en = w_ready && i_Sig_Write_Back_Enable_2 &&
                    (i_Destination_Write_Back_2 < c_num_regs);

  // --------------------------------------------------------------------------
  // Storage. No reset on the array: the sequencer loads it after reset.
  // WB2 is assigned last so it wins a same-address collision.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_regs[r_cnt] <= w_init_val;
      end else begin
        if (w_wr1_en) begin
          r_regs[i_Destination_Write_Back] <= i_Write_Back_Data;
        end
        if (w_wr2_en) begin
          r_regs[i_Destination_Write_Back_2] <= i_Write_Back_Data_2;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path with bypass: PC alias, then WB2, then WB, then storage.
  // Reads return zero until initialisation is complete.
  // --------------------------------------------------------------------------
  assign w_src = {i_SRC_3, i_SRC_2, i_SRC_1};

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rd[p] = '0;
      if (w_ready) begin
        if (w_src[p] >= c_num_regs) begin
          w_rd[p] = i_PC_Value;
        end else if (i_Sig_Write_Back_Enable_2 &&
                     (i_Destination_Write_Back_2 == w_src[p])) begin
          w_rd[p] = i_Write_Back_Data_2;
        end else if (i_Sig_Write_Back_Enable &&
                     (i_Destination_Write_Back == w_src[p])) begin
          w_rd[p] = i_Write_Back_Data;
        end else begin
          w_rd[p] = r_regs[w_src[p]];
        end
      end
    end
  end

  generate
    if (REGISTERED_READ != 0) begin : g_reg_read
      logic [2:0][DATA_WIDTH-1:0] r_rd;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rd <= '0;
        end else begin
          r_rd <= w_rd;
        end
      end

      assign o_A = r_rd[0];
      assign o_B = r_rd[1];
      assign o_C = r_rd[2];
    end else begin : g_comb_read
      assign o_A = w_rd[0];
      assign o_B = w_rd[1];
      assign o_C = w_rd[2];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/register_file_multiport.md
Name: register_file_multiport

Overview:
Parametrised successor to the pipeline's ARM general-purpose register file. It has three read ports (A, B and C, with C used for store data or the shift register) and two write ports (WB for write-back, WB2 for base-register update). Same-cycle write-to-read bypass is included. Registers are initialised by a sequencer that writes one register per cycle after reset. Addresses at or above NUM_REGS map to the PC input, so R15 reads return the PC.

Parameters:
DATA_WIDTH, 32, register and port data width
ADDR_WIDTH, 4, register address width; must satisfy 2^ADDR_WIDTH > NUM_REGS
NUM_REGS, 15, number of physical registers (R0..R14)
INIT_MODE, 1, init value per register: 0 = all zeros, 1 = register index zero-extended
REGISTERED_READ, 0, 0 = combinational reads; 1 = outputs registered, one-cycle latency

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_SRC_1  input  ADDR_WIDTH  read address, port A
i_SRC_2  input  ADDR_WIDTH  read address, port B
i_SRC_3  input  ADDR_WIDTH  read address, port C
i_Destination_Write_Back  input  ADDR_WIDTH  write address, port WB
i_Write_Back_Data  input  DATA_WIDTH  write data, port WB
i_Sig_Write_Back_Enable  input  1  write enable, port WB
i_Destination_Write_Back_2  input  ADDR_WIDTH  write address, port WB2
i_Write_Back_Data_2  input  DATA_WIDTH  write data, port WB2
i_Sig_Write_Back_Enable_2  input  1  write enable, port WB2
i_PC_Value  input  DATA_WIDTH  value returned for any read address >= NUM_REGS
o_A  output  DATA_WIDTH  read data, port A
o_B  output  DATA_WIDTH  read data, port B
o_C  output  DATA_WIDTH  read data, port C
o_Ready  output  1  high once initialisation is complete

Behaviour:
- Reset is synchronous and active-high. On any rising edge with reset=1:
  - state goes to INIT and the init counter goes to 0; no register is written.
  - o_Ready = 0.
  - Registered outputs (REGISTERED_READ=1) go to 0.
- INIT state, each edge with reset=0:
  - write reg[cnt] = (INIT_MODE ? cnt : 0), then cnt++.
  - on the edge that writes reg[NUM_REGS-1], go to READY.
  - o_Ready goes high after exactly NUM_REGS edges following reset release.
- INIT rules:
  - both write enables are ignored.
  - o_A, o_B and o_C read 0 in both read modes.
  - reset during INIT restarts initialisation at cnt=0.
- READY state writes:
  - each enabled port with address < NUM_REGS writes its register at the rising edge.
  - writes to addresses >= NUM_REGS are dropped silently.
  - both ports writing the same address: WB2 wins.
  - reset in READY returns to INIT; the full re-initialisation sequence runs again.
- READY state reads, per port, in priority order:
  - address >= NUM_REGS returns i_PC_Value (never bypassed).
  - else, enabled WB2 write to the same address returns i_Write_Back_Data_2.
  - else, enabled WB write to the same address returns i_Write_Back_Data.
  - else, the stored register value.
- REGISTERED_READ=0: outputs are combinational from the current-cycle address and write inputs (zero latency).
- REGISTERED_READ=1: the same read value is captured at the rising edge and presented the following cycle (latency 1).
  - the first valid registered output is the cycle after o_Ready rises.
- No storage exists for R15; NUM_REGS..2^ADDR_WIDTH-1 all alias to the PC.
- No hold/else branch is needed; registers keep their value when not written.

Test Plan:
1. Reset for 2 cycles, then release, with INIT_MODE=1 and NUM_REGS=15 -> o_Ready=0 for 15 edges, then 1; reading A=3, B=14, C=0 gives 3, 14, 0.
2. In READY, WB writes R5=0xDEADBEEF with i_SRC_1=5 in the same cycle -> o_A=0xDEADBEEF that cycle (comb mode); the next cycle reads 0xDEADBEEF from storage.
3. Both ports write R7 (WB=0x11, WB2=0x22) -> bypass and stored value are both 0x22; a simultaneous WB R1=0xAA with WB2 R2=0xBB updates both registers.
4. i_SRC_2=15 with i_PC_Value=0x1000 and a WB write to address 15 -> o_B=0x1000 and no register changes.
5. During INIT cycle 6, assert WB enable -> write ignored; assert reset at INIT cycle 6 -> o_Ready stays 0 for 15 edges after the new release.
6. With REGISTERED_READ=1, set i_SRC_3=4 while WB writes R4=0x55 -> o_C=0x55 exactly one cycle later; reset drives o_C to 0 at the next edge.
